line_reader: RTL and testbench

// Drains one scan line from the 480x16 line RAM and streams it as RGB565 pixel words to the display

---
 rtl/display_pkg.sv | 16 +
 rtl/line_reader_if.sv | 30 +++
 rtl/line_reader_pixel_fifo2.sv | 57 +++++
 rtl/line_reader.sv | 146 ++++++++++++++
 tb/tb_line_reader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// display_pkg: constants and types shared by the display pipeline.
//   LINE_PIXELS         - pixels in one scan line; also the line RAM depth
//   PIXEL_WIDTH         - RGB565 pixel word width
//   line_reader_state_t - line_reader FSM states
package display_pkg;

  localparam int LINE_PIXELS = 480;
  localparam int PIXEL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } line_reader_state_t;

endpackage

// File: rtl/line_reader_if.sv
// line_reader_if: valid/ready pixel stream from the line reader to the serializer.
//   pixelData  - RGB565 pixel word
//   pixelValid - pixelData holds a valid word
//   pixelReady - sink accepts; a transfer happens when pixelValid && pixelReady
//   pixelLast  - marks the final pixel of the line
// master = line reader side, slave = serializer side.
interface line_reader_if #(
  parameter int DATA_WIDTH = display_pkg::PIXEL_WIDTH
);

  logic [DATA_WIDTH-1:0] pixelData;
  logic                  pixelValid;
  logic                  pixelReady;
  logic                  pixelLast;

  modport master (
    output pixelData,
    output pixelValid,
    output pixelLast,
    input  pixelReady
  );

  modport slave (
    input  pixelData,
    input  pixelValid,
    input  pixelLast,
    output pixelReady
  );

endinterface

// File: rtl/line_reader_pixel_fifo2.sv
// pixel_fifo2: two-entry FIFO between the line RAM read port and the pixel stream.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   push, din    - write din when push (accepted if not full, or full with a pop this cycle)
//   pop          - drop the head word (ignored when empty)
//   head         - word at the head of the FIFO
//   count        - number of stored words (0..2)
module pixel_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  // When full, a push is only safe because the slot it lands in is being popped.
  assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/line_reader.sv
// line_reader: streams one scan line from the line RAM as RGB565 words.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   start        - request a line; honoured only while busy=0
//   pixelCount   - pixels in the line, sampled with start (clamped to LINE_PIXELS)
//   busy, done   - line in progress / one-cycle completion pulse
//   readAddress  - registered line RAM read address
//   readData     - line RAM output (synchronous RAM: address sampled one edge after issue)
//   pix          - pixel stream master port
//
// Read pipeline: an issue registers readAddress (addr_pending_r); the RAM samples it at
// the next edge and the word then sits on readData (in_flight_r) until captured into the
// FIFO. Issues are limited so that FIFO words plus the word on readData stay below two
// after this cycle's pop. That keeps one pixel per clock with ready high, and when the
// FIFO is full the readData word simply waits: no new address is issued, so the RAM keeps
// re-reading the same location and readData stays valid until there is room.
module line_reader #(
  parameter int LINE_PIXELS = display_pkg::LINE_PIXELS,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = display_pkg::PIXEL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pixelCount,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  line_reader_if.master         pix
);

  import display_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(LINE_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] ZERO      = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  line_reader_state_t    state_r;
  line_reader_state_t    state_s;
  logic [ADDR_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0] issued_r;
  logic [ADDR_WIDTH-1:0] popped_r;
  logic                  addr_pending_r;
  logic                  in_flight_r;
  logic [1:0]            fifo_count_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic [2:0]            occupancy_s;
  logic                  accept_s;
  logic                  pop_s;
  logic                  last_s;
  logic                  issue_s;
  logic                  capture_s;

  pixel_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture_s),
    .din   (readData),
    .pop   (pop_s),
    .head  (fifo_head_s),
    .count (fifo_count_s)
  );

  assign accept_s  = (state_r == IDLE) && start;
  assign pop_s     = pix.pixelValid && pix.pixelReady;
  assign last_s    = (popped_r == (count_r - ONE));
  assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, in_flight_r} - {2'b00, pop_s};
  assign issue_s   = (state_r == STREAM) && (issued_r < count_r) && (occupancy_s < 3'd2);
  // The readData word is taken as soon as the FIFO has (or is making) room.
  assign capture_s = in_flight_r && ((fifo_count_s != 2'd2) || pop_s);

  assign pix.pixelData  = fifo_head_s;
  assign pix.pixelValid = (fifo_count_s != 2'd0);
  assign pix.pixelLast  = pix.pixelValid && last_s;
  assign busy = (state_r != IDLE);
  assign done = (state_r == FINISH);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (pixelCount == ZERO) begin
            state_s = FINISH;
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (pop_s && last_s) begin
          state_s = FINISH;
        end else begin
          state_s = STREAM;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Line count, issue/pop counters and the RAM read pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r        <= ZERO;
      issued_r       <= ZERO;
      popped_r       <= ZERO;
      readAddress    <= ZERO;
      addr_pending_r <= 1'b0;
      in_flight_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        count_r  <= (pixelCount > MAX_COUNT) ? MAX_COUNT : pixelCount;
        issued_r <= ZERO;
        popped_r <= ZERO;
      end else begin
        if (issue_s) begin
          issued_r <= issued_r + ONE;
        end
        if (pop_s) begin
          popped_r <= popped_r + ONE;
        end
      end
      if (issue_s) begin
        readAddress <= issued_r;
      end
      addr_pending_r <= issue_s;
      in_flight_r    <= addr_pending_r | (in_flight_r & ~capture_s);
    end
  end

endmodule

// File: tb/tb_line_reader.sv
`timescale 1ns/1ps
module tb_line_reader;

  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int NPIX = 480;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] pixelCount;
  logic          busy;
  logic          done;
  logic [AW-1:0] readAddress;
  logic [DW-1:0] readData;

  line_reader_if #(.DATA_WIDTH(DW)) pix();

  line_reader #(
    .LINE_PIXELS (NPIX),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pixelCount  (pixelCount),
    .busy        (busy),
    .done        (done),
    .readAddress (readAddress),
    .readData    (readData),
    .pix         (pix)
  );

  always #5 clock = ~clock;

  // Line RAM model: synchronous read, address sampled on every rising edge.
  logic [DW-1:0] ram [NPIX];
  always @(posedge clock) readData <= (readAddress < NPIX) ? ram[readAddress] : 16'h0000;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q [$];   // {last, data} per expected pixel
  int e0 = 0;
  int ready_mode = 0;       // 0 high, 1 low after rel 4..9, 2 random, 3 low
  int check_ahead = 0;
  int xfer_cnt, last_cnt, first_rel, last_rel, done_cnt = 0, done_base, done_rel;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_line(input int n);
    int eff;
    eff = (n > NPIX) ? NPIX : n;
    for (int i = 0; i < eff; i++) exp_q.push_back({(i == eff - 1), ram[i]});
    xfer_cnt = 0; last_cnt = 0; first_rel = -1; last_rel = -1; done_rel = -1;
    done_base = done_cnt;
    pixelCount = AW'(n);
    start = 1'b1;
    e0 = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (done_cnt == done_base && t < limit) begin
      tick();
      t++;
    end
    chk("done_timeout", 32'(done_cnt != done_base), 32'd1);
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_once", 32'(done_cnt - done_base), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  // Downstream ready driver.
  initial begin
    pix.pixelReady = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        0:       pix.pixelReady = 1'b1;
        1:       pix.pixelReady = !((cyc - e0) >= 4 && (cyc - e0) <= 9);
        2:       pix.pixelReady = 1'($urandom_range(0, 1));
        3:       pix.pixelReady = 1'b0;
        default: pix.pixelReady = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard: checks every transfer against the expected queue.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(pix.pixelValid), 32'd1);
          chk("hold_data", 32'(pix.pixelData), 32'(prev_data));
          chk("hold_last", 32'(pix.pixelLast), 32'(prev_last));
        end
        if (check_ahead != 0 && busy && (cyc - e0) >= 1)
          chk("addr_ahead", 32'(readAddress <= xfer_cnt + 2), 32'd1);
        if (pix.pixelValid) begin
          chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
          if (first_rel < 0) first_rel = cyc - e0;
          if (pix.pixelReady && exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk("pixel_data", 32'(pix.pixelData), 32'(exp_w[DW-1:0]));
            chk("pixel_last", 32'(pix.pixelLast), 32'(exp_w[DW]));
            xfer_cnt++;
            if (pix.pixelLast) begin
              last_cnt++;
              last_rel = cyc - e0;
            end
          end
        end
        if (done) begin
          done_cnt++;
          if (done_rel < 0) done_rel = cyc - e0;
        end
        prev_stall = pix.pixelValid && !pix.pixelReady;
        prev_data  = pix.pixelData;
        prev_last  = pix.pixelLast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra_before;
    int n;
    reset = 1'b1; start = 1'b0; pixelCount = '0;
    for (int i = 0; i < NPIX; i++) ram[i] = DW'(i) ^ 16'hA5A5;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(readAddress), 32'd0);
    chk("rst_valid", 32'(pix.pixelValid), 32'd0);
    chk("rst_last", 32'(pix.pixelLast), 32'd0);
    chk("rst_data", 32'(pix.pixelData), 32'd0);
    reset = 1'b0;
    tick();

    // Full line at full rate.
    start_line(480);
    wait_done(1500);
    chk("full_first_rel", 32'(first_rel), 32'd3);
    chk("full_last_rel", 32'(last_rel), 32'd482);
    chk("full_done_rel", 32'(done_rel), 32'd483);
    chk("full_xfers", 32'(xfer_cnt), 32'd480);
    chk("full_last_once", 32'(last_cnt), 32'd1);

    // Backpressure window on a short line.
    ready_mode = 1;
    check_ahead = 1;
    start_line(5);
    while ((cyc - e0) < 5) tick();
    for (int k = 5; k <= 9; k++) begin
      chk("stall_valid", 32'(pix.pixelValid), 32'd1);
      chk("stall_data", 32'(pix.pixelData), 32'(ram[1]));
      tick();
    end
    wait_done(100);
    chk("bp_xfers", 32'(xfer_cnt), 32'd5);
    chk("bp_last_once", 32'(last_cnt), 32'd1);
    ready_mode = 0;
    check_ahead = 0;
    tick();

    // Empty line.
    ra_before = readAddress;
    start_line(0);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_done", 32'(done), 32'd1);
    tick();
    chk("zero_busy_end", 32'(busy), 32'd0);
    chk("zero_done_end", 32'(done), 32'd0);
    wait_done(10);
    chk("zero_addr", 32'(readAddress), 32'(ra_before));
    chk("zero_xfers", 32'(xfer_cnt), 32'd0);

    // Second start while busy is ignored.
    start_line(3);
    pixelCount = AW'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50);
    chk("restart_xfers", 32'(xfer_cnt), 32'd3);
    chk("restart_last_once", 32'(last_cnt), 32'd1);

    // Reset with two words buffered and one on the RAM output.
    ready_mode = 3;
    tick();
    start_line(5);
    while ((cyc - e0) < 6) tick();
    chk("pre_rst_valid", 32'(pix.pixelValid), 32'd1);
    chk("pre_rst_data", 32'(pix.pixelData), 32'(ram[0]));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(readAddress), 32'd0);
    chk("mid_rst_valid", 32'(pix.pixelValid), 32'd0);
    chk("mid_rst_last", 32'(pix.pixelLast), 32'd0);
    chk("mid_rst_data", 32'(pix.pixelData), 32'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    ready_mode = 0;
    tick();
    tick();
    start_line(2);
    wait_done(50);
    chk("post_rst_xfers", 32'(xfer_cnt), 32'd2);
    chk("post_rst_last_once", 32'(last_cnt), 32'd1);

    // Random contents, random backpressure, random lengths plus one oversized count.
    for (int i = 0; i < NPIX; i++) ram[i] = DW'($urandom_range(0, 65535));
    ready_mode = 2;
    for (int line = 0; line < 7; line++) begin
      n = (line == 6) ? 500 : $urandom_range(1, NPIX);
      start_line(n);
      wait_done(5000);
      chk("rand_xfers", 32'(xfer_cnt), 32'((n > NPIX) ? NPIX : n));
      chk("rand_last_once", 32'(last_cnt), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
